// File: rtl/spi_reg_config_pkg.sv
// Shared types and constants for the SPI register-configuration target.
package spi_reg_config_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned NUM_REGS   = 5;

    localparam logic [ADDR_W-1:0] ADDR_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY     = 7'h04;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

endpackage

// File: rtl/spi_reg_config_if.sv
// SPI pin bundle: the external master drives, the register target listens.
interface spi_reg_config_if;

    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input sclk, input copi, input ncs);

endinterface

// File: rtl/spi_reg_config_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with optional rise/fall detection.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_DETECT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync = chain_q[SYNC_STAGES-1];

    if (EDGE_DETECT) begin : g_edge
        logic hist_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hist_q <= 1'b0;
            end else begin
                hist_q <= sync;
            end
        end

        assign rise = sync & ~hist_q;
        assign fall = ~sync & hist_q;
    end else begin : g_no_edge
        assign rise = 1'b0;
        assign fall = 1'b0;
    end

endmodule

// File: rtl/spi_reg_config.sv
// SPI mode-0 write-only target: decodes 16-bit frames into the PWM peripheral's
// control registers, oversampling the SPI pins on clk.
module spi_reg_config #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = spi_reg_config_pkg::FRAME_BITS,
    parameter int unsigned MAX_ADDR    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_reg_config_if.slave         spi,
    output logic [7:0]              en_reg_out_7_0,
    output logic [7:0]              en_reg_out_15_8,
    output logic [7:0]              en_reg_pwm_7_0,
    output logic [7:0]              en_reg_pwm_15_8,
    output logic [7:0]              pwm_duty_cycle,
    output logic                    wr_strobe,
    output logic                    frame_err
);

    import spi_reg_config_pkg::*;

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVERRUN = CNT_W'(FRAME_BITS + 1);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic copi_sync, copi_rise, copi_fall;
    logic ncs_sync, ncs_rise, ncs_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi.sclk),
        .sync     (sclk_sync),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_sync_copi (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi.copi),
        .sync     (copi_sync),
        .rise     (copi_rise),
        .fall     (copi_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_sync_ncs (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi.ncs),
        .sync     (ncs_sync),
        .rise     (ncs_rise),
        .fall     (ncs_fall)
    );

    logic unused_sync_outputs;
    assign unused_sync_outputs = ^{sclk_sync, sclk_fall, copi_rise, copi_fall, ncs_sync};

    state_e                 state_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];

    logic                   frame_rw;
    logic [ADDR_W-1:0]      frame_addr;
    logic [DATA_W-1:0]      frame_data;
    logic                   frame_ok;

    assign frame_rw   = shift_q[FRAME_BITS-1];
    assign frame_addr = shift_q[FRAME_BITS-2 -: ADDR_W];
    assign frame_data = shift_q[DATA_W-1:0];
    // Short and overrun frames both fail the exact-count test.
    assign frame_ok   = (bit_cnt_q == CNT_FULL) && frame_rw &&
                        (frame_addr <= ADDR_W'(MAX_ADDR));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ncs_fall) begin
                        state_q   <= StShift;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                StShift: begin
                    // A final sclk bit coinciding with ncs_rise is still captured.
                    if (sclk_rise) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], copi_sync};
                        if (bit_cnt_q != CNT_OVERRUN) begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (ncs_rise) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    if (frame_ok) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (frame_addr == ADDR_W'(i)) begin
                                regs_q[i] <= frame_data;
                            end
                        end
                        wr_strobe <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    if (ncs_fall) begin
                        state_q   <= StShift;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_reg_config.sv
// Directed bench for spi_reg_config: SPI frames at clk/8, scoreboard of expected
// write/error pulses, and a register model compared against the outputs.
module tb_spi_reg_config;

    import spi_reg_config_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_reg_config_if spi ();

    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe, frame_err;

    spi_reg_config #(
        .SYNC_STAGES (2),
        .FRAME_BITS  (16),
        .MAX_ADDR    (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe),
        .frame_err       (frame_err)
    );

    typedef struct {
        bit         is_write;
        int         addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] exp_regs [NUM_REGS];
    int         checks = 0;
    int         failures = 0;
    int         err_pulses = 0;
    int         wr_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("%s_reg%0d", tag, i), 32'(dut_reg(i)), 32'(exp_regs[i]));
        end
    endtask

    // Scoreboard consumer: every strobe or error pulse must match the next expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (wr_strobe || frame_err)) begin
            if (wr_strobe) wr_pulses++;
            if (frame_err) err_pulses++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'b0, wr_strobe, frame_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {30'b0, wr_strobe, frame_err},
                      e.is_write ? 32'd2 : 32'd1);
                if (e.is_write && wr_strobe) begin
                    exp_regs[e.addr] = e.data;
                    check($sformatf("commit_addr%0d", e.addr), 32'(dut_reg(e.addr)),
                          32'(e.data));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit w, input int a, input logic [7:0] d);
        exp_t e;
        e.is_write = w;
        e.addr     = a;
        e.data     = d;
        sb.push_back(e);
    endtask

    task automatic frame_start();
        spi.ncs = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(4);
        spi.ncs = 1'b1;
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi.copi = bits[i];
            tick(4);
            spi.sclk = 1'b1;
            tick(4);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        frame_start();
        shift_bits(bits, n);
        frame_end();
        tick(10);
    endtask

    initial begin : stimulus
        int errs0;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;
        rst_n    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
        tick(4);
        check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check_regs("reset");
        rst_n = 1'b1;
        tick(4);

        // 1: plain write to address 0
        push(1'b1, int'(ADDR_OUT_7_0), 8'hF0);
        send(32'h80F0, 16);
        check("t1_sb_drained", 32'(sb.size()), 32'd0);
        check("t1_wr_pulses", 32'(wr_pulses), 32'd1);
        check_regs("t1");

        // 2: commit lands exactly SYNC_STAGES+2 edges after ncs rises
        push(1'b1, int'(ADDR_DUTY), 8'h80);
        frame_start();
        shift_bits(32'h8480, 16);
        tick(4);
        spi.ncs = 1'b1;
        tick(3);
        check("t2_duty_before", 32'(pwm_duty_cycle), 32'h00);
        tick(1);
        check("t2_duty_at_latency", 32'(pwm_duty_cycle), 32'h80);
        tick(10);
        check("t2_sb_drained", 32'(sb.size()), 32'd0);
        check_regs("t2");

        // 3: read frame and out-of-range address are both rejected
        errs0 = err_pulses;
        push(1'b0, 0, 8'h00);
        send(32'h00AA, 16);
        push(1'b0, 0, 8'h00);
        send(32'h85AA, 16);
        check("t3_err_pulses", 32'(err_pulses - errs0), 32'd2);
        check("t3_sb_drained", 32'(sb.size()), 32'd0);
        check_regs("t3");

        // 4: short and overrun frames rejected, then a valid write still commits
        errs0 = err_pulses;
        push(1'b0, 0, 8'h00);
        send(32'h40F0, 15);
        push(1'b0, 0, 8'h00);
        send(32'h180F0, 17);
        push(1'b1, int'(ADDR_OUT_15_8), 8'h3C);
        send(32'h813C, 16);
        check("t4_err_pulses", 32'(err_pulses - errs0), 32'd2);
        check("t4_sb_drained", 32'(sb.size()), 32'd0);
        check_regs("t4");

        // 5: reset mid-frame aborts it and clears everything
        frame_start();
        shift_bits(32'h82, 8);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
        shift_bits(32'h55, 8);
        frame_end();
        tick(10);
        check("t5_sb_drained", 32'(sb.size()), 32'd0);
        check_regs("t5");

        // 6: back-to-back writes with ncs high for only two clocks
        push(1'b1, int'(ADDR_PWM_7_0), 8'h5A);
        push(1'b1, int'(ADDR_PWM_15_8), 8'hA5);
        frame_start();
        shift_bits(32'h825A, 16);
        frame_end();
        tick(2);
        frame_start();
        shift_bits(32'h83A5, 16);
        frame_end();
        tick(10);
        check("t6_sb_drained", 32'(sb.size()), 32'd0);
        check_regs("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
